// File: rtl/tcdm_xbar_pkg.sv
// Shared types and helpers for the TCDM crossbar front end.
// Holds the index-width helper and the tracking-stage struct.
package tcdm_xbar_pkg;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic valid;
    logic expect_resp;
  } trk_t;

endpackage

// File: rtl/tcdm_resp_track.sv
// Fixed-depth tracker of granted transactions.
// Shifts every cycle; async clear drops everything in flight.
module tcdm_resp_track
  import tcdm_xbar_pkg::*;
#(
  parameter int AddrW   = 2,
  parameter int RespLat = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  trk_t             trk_in,
  input  logic [AddrW-1:0] idx_in,
  output trk_t             trk_out,
  output logic [AddrW-1:0] idx_out
);

  trk_t [RespLat-1:0]            stg_q;
  logic [RespLat-1:0][AddrW-1:0] idx_q;

  // shift register of stage entries, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stg_q <= '0;
      idx_q <= '0;
    end else begin
      for (int i = RespLat - 1; i > 0; i--) begin
        stg_q[i] <= stg_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
      stg_q[0] <= trk_in;
      idx_q[0] <= idx_in;
    end
  end

  assign trk_out = stg_q[RespLat-1];
  assign idx_out = idx_q[RespLat-1];

endmodule

// File: rtl/tcdm_addr_dec_resp_mux.sv
// Per-master TCDM front end: bank decode, grant, response return.
// Define TCDM_RESP_REG_EN to register vld_o/rdata_o (+1 cycle).
module tcdm_addr_dec_resp_mux
  import tcdm_xbar_pkg::*;
#(
  parameter int NumOut        = 4,
  parameter int ReqDataWidth  = 32,
  parameter int RespDataWidth = 32,
  parameter int RespLat       = 1,
  parameter int BroadCastOn   = 0,
  parameter int WriteRespOn   = 1,
  localparam int AddrW        = idx_width(NumOut)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   req_i,
  input  logic [AddrW-1:0]                       add_i,
  input  logic                                   wen_i,
  input  logic [ReqDataWidth-1:0]                data_i,
  output logic                                   gnt_o,
  output logic                                   vld_o,
  output logic [RespDataWidth-1:0]               rdata_o,
  output logic [NumOut-1:0]                      req_o,
  input  logic [NumOut-1:0]                      gnt_i,
  input  logic [NumOut-1:0]                      vld_i,
  output logic [NumOut-1:0][ReqDataWidth-1:0]    data_o,
  input  logic [NumOut-1:0][RespDataWidth-1:0]   rdata_i
);

  localparam logic BcastEn = (BroadCastOn != 0);
  localparam logic WrResp  = (WriteRespOn != 0);

  logic [AddrW-1:0]  idx_eff;
  logic [NumOut-1:0] dec;
  logic              bcast;
  trk_t              trk_in;
  trk_t              trk_s;
  logic [AddrW-1:0]  idx_trk;
  logic [AddrW-1:0]  idx_s;
  logic              sel_vld;
  logic [RespDataWidth-1:0] sel_data;
  logic              resp_vld;
  logic [RespDataWidth-1:0] resp_data;

  assign idx_eff = (NumOut == 1) ? '0 : add_i;
  assign bcast   = BcastEn & wen_i;

  // one-hot bank decode; out-of-range indices select nothing
  always_comb begin
    dec = '0;
    for (int i = 0; i < NumOut; i++) begin
      dec[i] = (32'(idx_eff) == i);
    end
  end

  // per-bank request and combinational grant
  always_comb begin
    req_o = '0;
    gnt_o = 1'b0;
    if (req_i) begin
      if (bcast) begin
        req_o = '1;
        gnt_o = &gnt_i;
      end else begin
        req_o = dec;
        gnt_o = |(dec & gnt_i);
      end
    end
  end

  assign data_o = {NumOut{data_i}};

  assign trk_in.valid       = req_i & gnt_o;
  assign trk_in.expect_resp = ~wen_i | WrResp;
  assign idx_trk            = bcast ? '0 : idx_eff;

  tcdm_resp_track #(
    .AddrW   (AddrW),
    .RespLat (RespLat)
  ) u_track (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .trk_in  (trk_in),
    .idx_in  (idx_trk),
    .trk_out (trk_s),
    .idx_out (idx_s)
  );

  // select the tracked bank's valid and read data
  always_comb begin
    sel_vld  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NumOut; i++) begin
      if (32'(idx_s) == i) begin
        sel_vld  = vld_i[i];
        sel_data = rdata_i[i];
      end
    end
  end

  assign resp_vld  = trk_s.valid & trk_s.expect_resp & sel_vld;
  assign resp_data = resp_vld ? sel_data : '0;

`ifdef TCDM_RESP_REG_EN
  // optional output register on the response path
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      vld_o   <= resp_vld;
      rdata_o <= resp_data;
    end
  end
`else
  assign vld_o   = resp_vld;
  assign rdata_o = resp_data;
`endif

endmodule

// File: tb/tb_tcdm_addr_dec_resp_mux.sv
// Bench for tcdm_addr_dec_resp_mux: two configurations,
// responses checked every cycle against a due-cycle queue.
module tb_tcdm_addr_dec_resp_mux;

`ifdef TCDM_RESP_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT_A = 1 + EXTRA;
  localparam int LAT_B = 3 + EXTRA;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t qa[$];
  exp_t qb[$];

  logic             a_req, a_wen, a_gnt_o, a_vld_o;
  logic [1:0]       a_add;
  logic [31:0]      a_data, a_rdata_o;
  logic [3:0]       a_req_o, a_gnt, a_vld;
  logic [3:0][31:0] a_data_o, a_rdata;

  logic             b_req, b_wen, b_gnt_o, b_vld_o;
  logic [1:0]       b_add;
  logic [31:0]      b_data, b_rdata_o;
  logic [3:0]       b_req_o, b_gnt, b_vld;
  logic [3:0][31:0] b_data_o, b_rdata;

  logic             ev;
  logic [31:0]      ed;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tcdm_addr_dec_resp_mux #(
    .NumOut(4), .ReqDataWidth(32), .RespDataWidth(32),
    .RespLat(1), .BroadCastOn(0), .WriteRespOn(1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .add_i(a_add),
    .wen_i(a_wen), .data_i(a_data), .gnt_o(a_gnt_o),
    .vld_o(a_vld_o), .rdata_o(a_rdata_o), .req_o(a_req_o),
    .gnt_i(a_gnt), .vld_i(a_vld), .data_o(a_data_o),
    .rdata_i(a_rdata)
  );

  tcdm_addr_dec_resp_mux #(
    .NumOut(4), .ReqDataWidth(32), .RespDataWidth(32),
    .RespLat(3), .BroadCastOn(1), .WriteRespOn(0)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .add_i(b_add),
    .wen_i(b_wen), .data_i(b_data), .gnt_o(b_gnt_o),
    .vld_o(b_vld_o), .rdata_o(b_rdata_o), .req_o(b_req_o),
    .gnt_i(b_gnt), .vld_i(b_vld), .data_o(b_data_o),
    .rdata_i(b_rdata)
  );

  // response monitor: every cycle, both DUTs
  always @(negedge clk) begin
    ev = 1'b0;
    ed = '0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      ev = 1'b1;
      ed = qa[0].data;
      qa.delete(0);
    end
    checks++;
    if (a_vld_o !== ev || a_rdata_o !== ed) begin
      errors++;
      $display("FAIL resp_a cyc=%0d got vld=%b rdata=%h expected vld=%b rdata=%h",
               cyc, a_vld_o, a_rdata_o, ev, ed);
    end
    ev = 1'b0;
    ed = '0;
    if (qb.size() > 0 && qb[0].due == cyc) begin
      ev = 1'b1;
      ed = qb[0].data;
      qb.delete(0);
    end
    checks++;
    if (b_vld_o !== ev || b_rdata_o !== ed) begin
      errors++;
      $display("FAIL resp_b cyc=%0d got vld=%b rdata=%h expected vld=%b rdata=%h",
               cyc, b_vld_o, b_rdata_o, ev, ed);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_req = 0; a_wen = 0; a_add = 0; a_gnt = 0;
    b_req = 0; b_wen = 0; b_add = 0; b_gnt = 0;
  endtask

  task automatic chk_a(string nm, logic [3:0] ereq, logic egnt);
    checks++;
    if (a_req_o !== ereq || a_gnt_o !== egnt) begin
      errors++;
      $display("FAIL %s got req_o=%b gnt_o=%b expected req_o=%b gnt_o=%b",
               nm, a_req_o, a_gnt_o, ereq, egnt);
    end
  endtask

  task automatic chk_b(string nm, logic [3:0] ereq, logic egnt);
    checks++;
    if (b_req_o !== ereq || b_gnt_o !== egnt) begin
      errors++;
      $display("FAIL %s got req_o=%b gnt_o=%b expected req_o=%b gnt_o=%b",
               nm, b_req_o, b_gnt_o, ereq, egnt);
    end
  endtask

  task automatic test_reset();
    idle_all();
    a_data = 32'h0; b_data = 32'h0;
    a_vld = 4'b1111; b_vld = 4'b1111;
    a_rdata[0] = 32'hA000_0000; a_rdata[1] = 32'hA111_1111;
    a_rdata[2] = 32'hDEAD_BEEF; a_rdata[3] = 32'hA333_3333;
    b_rdata[0] = 32'h1111_0000; b_rdata[1] = 32'h2222_0001;
    b_rdata[2] = 32'h3333_0002; b_rdata[3] = 32'h4444_0003;
    repeat (3) step();
    chk_a("reset_idle_a", 4'b0000, 1'b0);
    checks++;
    if (a_vld_o !== 1'b0 || b_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_vld got a=%b b=%b expected 0 0", a_vld_o, b_vld_o);
    end
    // decode is not masked by reset
    a_req = 1; a_add = 1; a_gnt = 4'b0010;
    #1;
    chk_a("reset_comb_dec", 4'b0010, 1'b1);
    a_req = 0;
    step();
    rst = 0;
    repeat (2) step();
  endtask

  task automatic test_load_a();
    a_vld = 4'b0100;
    a_req = 1; a_wen = 0; a_add = 2; a_gnt = 4'b0100;
    a_data = 32'hCAFE_0123;
    #1;
    chk_a("load_a_dec", 4'b0100, 1'b1);
    checks++;
    if (a_data_o !== {4{32'hCAFE_0123}}) begin
      errors++;
      $display("FAIL data_repl got %h expected %h", a_data_o, {4{32'hCAFE_0123}});
    end
    qa.push_back('{cyc + LAT_A, 32'hDEAD_BEEF});
    step();
    idle_all();
    repeat (3) step();
    a_vld = 4'b1111;
  endtask

  task automatic test_gnt_miss_a();
    a_vld = 4'b0100;
    a_req = 1; a_wen = 0; a_add = 2; a_gnt = 4'b1011;
    #1;
    chk_a("gnt_miss_a", 4'b0100, 1'b0);
    step();
    idle_all();
    repeat (3) step();
    a_vld = 4'b1111;
  endtask

  task automatic test_other_bank_vld_a();
    a_vld = 4'b1101;
    a_req = 1; a_wen = 0; a_add = 1; a_gnt = 4'b0010;
    #1;
    chk_a("other_vld_a", 4'b0010, 1'b1);
    step();
    idle_all();
    repeat (3) step();
    a_vld = 4'b1111;
  endtask

  task automatic test_store_a();
    a_req = 1; a_wen = 1; a_add = 3; a_gnt = 4'b1000;
    #1;
    chk_a("store_a", 4'b1000, 1'b1);
    qa.push_back('{cyc + LAT_A, 32'hA333_3333});
    step();
    idle_all();
    repeat (3) step();
  endtask

  task automatic test_back_to_back_b();
    int banks[3] = '{0, 1, 3};
    logic [3:0] oh;
    foreach (banks[k]) begin
      oh = 4'b0001 << banks[k];
      b_req = 1; b_wen = 0; b_add = 2'(banks[k]); b_gnt = oh;
      #1;
      chk_b($sformatf("b2b_b_%0d", k), oh, 1'b1);
      qb.push_back('{cyc + LAT_B, b_rdata[banks[k]]});
      step();
    end
    idle_all();
    repeat (6) step();
  endtask

  task automatic test_bcast_store_b();
    b_req = 1; b_wen = 1; b_add = 2; b_gnt = 4'b0111;
    #1;
    chk_b("bcast_partial", 4'b1111, 1'b0);
    step();
    b_gnt = 4'b1111;
    #1;
    chk_b("bcast_full", 4'b1111, 1'b1);
    step();
    // loads are not broadcast
    b_wen = 0; b_gnt = 4'b1011;
    #1;
    chk_b("bcast_load_miss", 4'b0100, 1'b0);
    step();
    idle_all();
    repeat (6) step();
  endtask

  task automatic test_reset_mid_b();
    b_req = 1; b_wen = 0; b_add = 0; b_gnt = 4'b0001;
    step();
    b_add = 1; b_gnt = 4'b0010;
    step();
    idle_all();
    rst = 1;
    repeat (2) step();
    rst = 0;
    repeat (5) step();
    checks++;
    if (b_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_vld got %b expected 0", b_vld_o);
    end
    b_req = 1; b_wen = 0; b_add = 3; b_gnt = 4'b1000;
    #1;
    chk_b("after_reset_b", 4'b1000, 1'b1);
    qb.push_back('{cyc + LAT_B, b_rdata[3]});
    step();
    idle_all();
    repeat (6) step();
  endtask

  initial begin
    test_reset();
    test_load_a();
    test_gnt_miss_a();
    test_other_bank_vld_a();
    test_store_a();
    test_back_to_back_b();
    test_bcast_store_b();
    test_reset_mid_b();
    repeat (2) step();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain got pending a=%0d b=%0d expected 0 0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcdm_addr_dec_resp_mux.md
Name: tcdm_addr_dec_resp_mux

Overview:
- Per-initiator front end of the TCDM logarithmic crossbar.
- Decodes the bank index of one master request into a one-hot request vector toward NumOut per-bank round-robin arbiters, and returns the combinational grant.
- Tracks each granted transaction through a fixed response latency, then routes the selected bank's valid and read data back to the master.
- One instance per master in the crossbar.

Parameters:
- NumOut, 4: number of targets (banks); must be ≥1.
- ReqDataWidth, 32: request payload width (wdata plus any sideband).
- RespDataWidth, 32: response data width.
- RespLat, 1: cycles from grant to response at the bank interface; must be ≥1.
- BroadCastOn, 0: when 1, stores are broadcast to all banks.
- WriteRespOn, 1: when 1, stores also produce vld_o; when 0, only loads do.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  master request.
- add_i  in  AddrW=max(1,$clog2(NumOut))  bank index; ignored when NumOut=1.
- wen_i  in  1  1=store, 0=load.
- data_i  in  ReqDataWidth  request payload.
- gnt_o  out  1  grant, combinational from req_i/add_i/gnt_i.
- vld_o  out  1  response valid.
- rdata_o  out  RespDataWidth  response data.
- req_o  out  NumOut  per-bank request.
- gnt_i  in  NumOut  per-bank grant from the arbiters.
- vld_i  in  NumOut  per-bank response valid.
- data_o  out  NumOut×ReqDataWidth  payload to each bank.
- rdata_i  in  NumOut×RespDataWidth  per-bank read data.

Behaviour:
- Decode: req_o = req_i ? (1<<add_i) : 0.
- add_i ≥ NumOut (non-power-of-two NumOut): req_o=0 and gnt_o=0; the request stalls forever and is not an error response.
- Broadcast case (BroadCastOn=1, req_i=1, wen_i=1): req_o = all ones; gnt_o = &gnt_i.
- Otherwise gnt_o = |(req_o & gnt_i).
- data_o: every lane carries data_i (replicated, no gating).
- Tracking pipeline: RespLat stages.
  - Each stage holds {valid, idx[AddrW], expect_resp}.
  - Stage 0 is loaded each cycle with valid = req_i & gnt_o, idx = add_i (0 for broadcast), expect_resp = !wen_i | WriteRespOn.
  - The pipeline shifts every cycle; there are no stalls.
  - A new grant may occur every cycle, so up to RespLat transactions are in flight.
- Response at the last stage S:
  - vld_o = S.valid & S.expect_resp & vld_i[S.idx].
  - rdata_o = rdata_i[S.idx] when vld_o=1, else 0.
- A response is thus visible RespLat cycles after the gnt_o cycle. vld_i of any other bank is ignored.
- Reset: all stage valid bits are cleared asynchronously; idx/expect_resp are reset to 0.
  - During reset and on the first RespLat cycles after it: vld_o=0 and rdata_o=0.
  - req_o/gnt_o/data_o stay combinational and are not masked by reset.
  - Reset mid-operation drops all in-flight responses; none are delivered.
- Simultaneous events: grant in cycle t and response of transaction t−RespLat in the same cycle are independent.
- NumOut=1: req_o[0]=req_i and gnt_o=req_i&gnt_i[0]; idx is always 0.

Optional Feature:
- Macro: TCDM_RESP_REG_EN.
- Defined: vld_o and rdata_o are registered. Total latency is RespLat+1; the register resets to 0 asynchronously.
- Undefined: vld_o/rdata_o are combinational from the last pipeline stage and vld_i/rdata_i, with latency RespLat.

Decomposition:
- Package tcdm_xbar_pkg: function idx_width(n)=max(1,$clog2(n)), and the typedef of the tracking stage struct {valid, expect_resp} (idx kept as a parameterised vector).
- Sub-module tcdm_resp_track: RespLat-deep shift register of tracking entries with asynchronous clear.
- The decoder and response mux stay in the top.

Test Plan:
- NumOut=4, RespLat=1:
  - Load with add_i=2 and gnt_i=4'b0100 → req_o=4'b0100, gnt_o=1.
  - Next cycle vld_i=4'b0100 and rdata_i[2]=0xDEADBEEF → vld_o=1, rdata_o=0xDEADBEEF.
- gnt_i=4'b1011 with add_i=2 → gnt_o=0; next cycle vld_o=0 even when vld_i[2]=1.
- RespLat=3, back-to-back granted loads to banks 0,1,3 in cycles 0–2, each bank returning a distinct value → vld_o high in cycles 3,4,5 with the matching data, in order.
- WriteRespOn=0: granted store → vld_o stays 0. WriteRespOn=1: the same store → vld_o=1 after RespLat.
- BroadCastOn=1, store with gnt_i=4'b0111 → req_o=4'b1111, gnt_o=0; with gnt_i=4'b1111 → gnt_o=1.
- Reset asserted while 2 loads are in flight (RespLat=3) → vld_o=0 throughout and after release; the next grant responds normally.
